// File: rtl/sya_act_feeder.sv
// ---------------------------------------------------------------------------
// sya_act_feeder
//
// Activation feeder for the left edge of one systolic-array PE row (one
// instance per row). It pops activations from the activation buffer over a
// valid/ready handshake and presents them to the row as activation, valid and
// accumulate-reset. The job is framed into cfg_num_pt output points of
// cfg_len_k reduction beats each. A final flush beat selects the last partial
// sum out of the row.
//
// Optional feature (compile-time macro SYA_FEEDER_BUBBLE_CNT_EN):
//   defined   -> bubble_cnt counts STREAM cycles with arr_rdy=1 and src_vld=0.
//                It clears on an accepted cfg_start and saturates at all-ones.
//   undefined -> bubble_cnt is tied to 0 and no counter logic exists.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_start         one-cycle start pulse; cfg_len_k/cfg_num_pt sampled here
//   cfg_len_k         reduction beats per output point
//   cfg_num_pt        output points per job
//   busy              job in progress
//   done              one-cycle registered pulse at job end
//   src_vld/src_act   upstream activation valid / data
//   src_rdy           pop strobe to upstream (combinational)
//   arr_rdy           row-wide enable; the row samples act_* on edges where 1
//   act_vld/act_out   row left valid / activation inputs
//   acc_reset         row left accumulate-reset input
//   bubble_cnt        bubble statistic (see above)
//   dbg_state         current FSM state (0 IDLE, 1 STREAM, 2 FLUSH, 3 DRAIN)
//
// Handshake: an activation transfers on a rising clk edge where src_vld and
// src_rdy are both 1. src_rdy is only raised in STREAM when the row is enabled
// (arr_rdy=1) and src_vld is already high, so it acts as a pop strobe; the
// popped data appears on act_* one edge later.
// ---------------------------------------------------------------------------
module sya_act_feeder #(
  parameter int ACT_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic [CNT_WIDTH-1:0] cfg_len_k,
  input  logic [CNT_WIDTH-1:0] cfg_num_pt,
  output logic                 busy,
  output logic                 done,
  input  logic                 src_vld,
  input  logic [ACT_WIDTH-1:0] src_act,
  output logic                 src_rdy,
  input  logic                 arr_rdy,
  output logic                 act_vld,
  output logic [ACT_WIDTH-1:0] act_out,
  output logic                 acc_reset,
  output logic [CNT_WIDTH-1:0] bubble_cnt,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_q,     state_d;
  logic [CNT_WIDTH-1:0] len_k_q,     len_k_d;
  logic [CNT_WIDTH-1:0] num_pt_q,    num_pt_d;
  logic [CNT_WIDTH-1:0] k_cnt_q,     k_cnt_d;
  logic [CNT_WIDTH-1:0] pt_cnt_q,    pt_cnt_d;
  logic                 act_vld_q,   act_vld_d;
  logic [ACT_WIDTH-1:0] act_out_q,   act_out_d;
  logic                 acc_reset_q, acc_reset_d;
  logic                 done_q,      done_d;

  logic last_k;
  logic last_pt;
  logic start_ok;

  // Wrap points of the reduction and point counters, against latched config.
  assign last_k   = (k_cnt_q == (len_k_q - CNT_ONE));
  assign last_pt  = (pt_cnt_q == (num_pt_q - CNT_ONE));
  // cfg_start is only honoured while idle; a pulse during a job is dropped.
  assign start_ok = (state_q == ST_IDLE) && cfg_start;

  always_comb begin
    state_d     = state_q;
    len_k_d     = len_k_q;
    num_pt_d    = num_pt_q;
    k_cnt_d     = k_cnt_q;
    pt_cnt_d    = pt_cnt_q;
    act_vld_d   = act_vld_q;
    act_out_d   = act_out_q;
    acc_reset_d = acc_reset_q;
    done_d      = 1'b0;
    src_rdy     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        act_vld_d   = 1'b0;
        act_out_d   = '0;
        acc_reset_d = 1'b0;
        if (cfg_start) begin
          len_k_d  = cfg_len_k;
          num_pt_d = cfg_num_pt;
          k_cnt_d  = '0;
          pt_cnt_d = '0;
          // An empty job emits nothing and finishes immediately.
          if ((cfg_len_k == '0) || (cfg_num_pt == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_STREAM;
          end
        end
      end

      ST_STREAM: begin
        src_rdy = arr_rdy & src_vld;
        if (arr_rdy) begin
          if (src_vld) begin
            act_vld_d   = 1'b1;
            act_out_d   = src_act;
            acc_reset_d = (k_cnt_q == '0);
            if (last_k) begin
              k_cnt_d  = '0;
              pt_cnt_d = pt_cnt_q + CNT_ONE;
              if (last_pt) begin
                state_d = ST_FLUSH;
              end
            end else begin
              k_cnt_d = k_cnt_q + CNT_ONE;
            end
          end else begin
            // Bubble: counters hold, so a due acc_reset rides on the next
            // real beat instead of being lost.
            act_vld_d   = 1'b0;
            act_out_d   = '0;
            acc_reset_d = 1'b0;
          end
        end
      end

      ST_FLUSH: begin
        // Zero activation with acc_reset selects the final sum out of the
        // row; the zero product folded into the next accumulation is harmless.
        if (arr_rdy) begin
          act_vld_d   = 1'b1;
          act_out_d   = '0;
          acc_reset_d = 1'b1;
          state_d     = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (arr_rdy) begin
          act_vld_d   = 1'b0;
          act_out_d   = '0;
          acc_reset_d = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_k_q     <= '0;
      num_pt_q    <= '0;
      k_cnt_q     <= '0;
      pt_cnt_q    <= '0;
      act_vld_q   <= 1'b0;
      act_out_q   <= '0;
      acc_reset_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_k_q     <= len_k_d;
      num_pt_q    <= num_pt_d;
      k_cnt_q     <= k_cnt_d;
      pt_cnt_q    <= pt_cnt_d;
      act_vld_q   <= act_vld_d;
      act_out_q   <= act_out_d;
      acc_reset_q <= acc_reset_d;
      done_q      <= done_d;
    end
  end

`ifdef SYA_FEEDER_BUBBLE_CNT_EN
  logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (start_ok) begin
      bubble_cnt_d = '0;
    end else if ((state_q == ST_STREAM) && arr_rdy && !src_vld &&
                 (bubble_cnt_q != {CNT_WIDTH{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign bubble_cnt      = '0;
`endif

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign act_vld   = act_vld_q;
  assign act_out   = act_out_q;
  assign acc_reset = acc_reset_q;
  assign dbg_state = state_q;

endmodule

// File: doc/sya_act_feeder.md
# sya_act_feeder

Activation feeder for one systolic-array row. It pops activations from an upstream buffer over a valid/ready handshake and drives the row's left-edge inputs: activation, valid and accumulate-reset. The row-wide stall enable is honoured. It frames the stream into `cfg_num_pt` output points of `cfg_len_k` reduction beats each. A final flush beat drains the last partial sum. It sits between the activation buffer and the left edge of a PE row; one instance per row.

## Interface
Parameters:
- `ACT_WIDTH`, 8, activation width.
- `CNT_WIDTH`, 16, width of the length/point counters and config fields.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_start` in 1: one-cycle start pulse. Config is sampled on this pulse.
- `cfg_len_k` in CNT_WIDTH: reduction beats per output point.
- `cfg_num_pt` in CNT_WIDTH: output points per job.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle pulse at job end.
- `src_vld` in 1: upstream activation valid.
- `src_act` in ACT_WIDTH: upstream activation.
- `src_rdy` out 1: pop strobe to upstream.
- `arr_rdy` in 1: row-wide enable/stall. The row samples the outputs on edges where this is 1.
- `act_vld` out 1: drives the row's left valid input.
- `act_out` out ACT_WIDTH: drives the row's left activation input.
- `acc_reset` out 1: drives the row's left accumulate-reset input.
- `bubble_cnt` out CNT_WIDTH: bubble statistic; see Configuration.

## Operation
- FSM states: IDLE, STREAM, FLUSH, DRAIN.
- IDLE: on `cfg_start`, latch `cfg_len_k`/`cfg_num_pt` and clear `k_cnt`/`pt_cnt`.
  - If either field is 0: no beats are emitted, `done` pulses the next cycle, and the FSM stays in IDLE.
  - Otherwise go to STREAM.
- `cfg_start` while `busy`=1 is ignored.
- STREAM: `src_rdy` = `arr_rdy` & `src_vld`.
  - Pop edge (`src_rdy`=1): the output register loads `act_out`=`src_act`, `act_vld`=1, and `acc_reset`=(`k_cnt`==0).
  - Counters on a pop: `k_cnt`++; wraps to 0 at `len_k`-1, and `pt_cnt`++ on the wrap.
  - Last beat of the last point: go to FLUSH.
  - Edge with `arr_rdy`=1 and `src_vld`=0: load a bubble (`act_vld`=0, `act_out`=0, `acc_reset`=0). Counters hold, so a pending `acc_reset` is deferred to the next real beat, never dropped.
- FLUSH: on an `arr_rdy` edge, load the flush beat (`act_vld`=1, `act_out`=0, `acc_reset`=1). This selects the final sum; the zero product it accumulates is harmless. Go to DRAIN.
- DRAIN: on an `arr_rdy` edge, load zeros, pulse `done`, clear `busy`, go to IDLE.
- `arr_rdy`=0: the output register, counters and state all hold, and `src_rdy`=0.
- Counters are unsigned CNT_WIDTH and compare against latched values. A job has at most 2^CNT_WIDTH-1 points × 2^CNT_WIDTH-1 beats.

## Timing
- Reset values: `busy`, `done`, `src_rdy`, `act_vld`, `act_out`, `acc_reset` and `bubble_cnt` are all 0, and the FSM is in IDLE.
- Reset mid-job discards the job immediately; no flush beat is emitted.
- `cfg_start` sampled at edge 0 → `busy`=1 and STREAM from cycle 1.
- `src_rdy` is combinational within the cycle. The popped data appears on `act_*` one edge later.
- With `src_vld`=`arr_rdy`=1 continuously, K×N beats are popped on edges 1..K·N.
  - Beat j is visible after edge j.
  - Flush beat is visible after edge K·N+1.
  - Zeros are loaded at edge K·N+2, and `done`=1 for the cycle after edge K·N+2.
  - `busy` falls with that same edge.
- `done` is registered and lasts exactly one cycle.

## Configuration
- `SYA_FEEDER_BUBBLE_CNT_EN` defined:
  - `bubble_cnt` counts cycles in STREAM with `arr_rdy`=1 and `src_vld`=0.
  - It clears on an accepted `cfg_start` and saturates at all-ones.
- `SYA_FEEDER_BUBBLE_CNT_EN` undefined: `bubble_cnt` is tied to 0 and no counter logic is instantiated.

## Test plan
- Basic job: K=4, N=2, `src_vld`/`arr_rdy` always 1, acts 1..8.
  - Expect `act_out` 1..8 after edges 1..8, with `acc_reset` on acts 1 and 5.
  - Expect the flush beat (0, vld=1, reset=1) after edge 9 and `done` after edge 10.
- Stall: same job with `arr_rdy`=0 for cycles 3–5.
  - Outputs and `src_rdy` freeze.
  - Sequence is unchanged; `done` is delayed by 3 cycles.
- Source bubble: K=2, N=2, `src_vld`=0 exactly on the cycle the 3rd beat would pop.
  - Expect one bubble beat (vld=0, reset=0), then act 3 with `acc_reset`=1.
  - With the macro defined, `bubble_cnt`=1.
- Degenerate config: start with `cfg_len_k`=0, N=5.
  - No `src_rdy` and no `act_vld`.
  - `done` pulses the cycle after start; `busy` stays 0.
- Start while busy plus reset: pulse `cfg_start` mid-job and expect no effect. Then assert `rst_n`=0 mid-job:
  - All outputs go to 0 immediately, with no flush beat.
  - A new job after release runs cleanly.
